// File: rtl/qtz_sched_ctrl.sv
// Stallable, abortable sequencer for the quantizing datapath: steps chunk/segment
// selects, strobes the output register bank and hands finished segments downstream.
module qtz_sched_ctrl #(
    parameter int NUM_CHUNKS      = 4,
    parameter int NUM_SEGMENTS    = 2,
    parameter int FEATURE_COUNT   = 617,
    parameter int FEATURES_PER_CC = 155,
    parameter int SETTLE_CYCLES   = 1,
    localparam int CTR_W = (NUM_CHUNKS > 1)    ? $clog2(NUM_CHUNKS)    : 1,
    localparam int SEG_W = (NUM_SEGMENTS > 1)  ? $clog2(NUM_SEGMENTS)  : 1,
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic [CTR_W-1:0] ctr,
    output logic [SEG_W-1:0] hv_segment,
    output logic             load_en,
    output logic [7:0]       lane_count,
    output logic             out_valid,
    output logic             busy,
    output logic             mapping_done
);

    localparam logic [CTR_W-1:0] CTR_LAST   = CTR_W'(NUM_CHUNKS - 1);
    localparam logic [SEG_W-1:0] SEG_LAST   = SEG_W'(NUM_SEGMENTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       FULL_LANES = 8'(FEATURES_PER_CC);
    localparam logic [7:0]       LAST_LANES = 8'(FEATURE_COUNT - (NUM_CHUNKS - 1) * FEATURES_PER_CC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            seg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Abort overrides everything, including a pending handshake; en=0 freezes all.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            ctr_d   = '0;
            seg_d   = '0;
            cnt_d   = '0;
        end else if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SETTLE;
                        ctr_d   = '0;
                        seg_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (ctr_q != CTR_LAST) begin
                        ctr_d   = ctr_q + CTR_W'(1);
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (seg_q != SEG_LAST) begin
                            seg_d   = seg_q + SEG_W'(1);
                            ctr_d   = '0;
                            cnt_d   = '0;
                            state_d = S_SETTLE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    ctr_d   = '0;
                    seg_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Strobes are suppressed while disabled so a stalled capture/done fires once on resume.
    assign load_en      = (state_q == S_CAPTURE) && en;
    assign mapping_done = (state_q == S_DONE) && en;
    assign out_valid    = (state_q == S_HOLD);
    assign busy         = (state_q != S_IDLE);
    assign ctr          = ctr_q;
    assign hv_segment   = seg_q;
    assign lane_count   = (ctr_q == CTR_LAST) ? LAST_LANES : FULL_LANES;

endmodule

// File: tb/tb_qtz_sched_ctrl.sv
// Self-checking bench for qtz_sched_ctrl: directed schedule table, corner-case
// sequences and randomized stimulus against a position-based reference model.
module tb_qtz_sched_ctrl;

    localparam int NC      = 4;
    localparam int NS      = 2;
    localparam int FC      = 617;
    localparam int FPC     = 155;
    localparam int SC      = 1;
    localparam int SEG_LEN = NC * (SC + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] ctr;
    logic [0:0] hv_segment;
    logic       load_en;
    logic [7:0] lane_count;
    logic       out_valid;
    logic       busy;
    logic       mapping_done;

    int tests = 0;
    int fails = 0;

    qtz_sched_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .abort        (abort),
        .out_ready    (out_ready),
        .ctr          (ctr),
        .hv_segment   (hv_segment),
        .load_en      (load_en),
        .lane_count   (lane_count),
        .out_valid    (out_valid),
        .busy         (busy),
        .mapping_done (mapping_done)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current segment rather than FSM states.
    bit m_valid_ref = 0;
    bit m_active = 0;
    bit m_done = 0;
    int m_seg = 0;
    int m_pos = 0;

    logic       obs_load, obs_valid, obs_done, obs_busy;
    logic [1:0] obs_ctr;
    logic [0:0] obs_seg;
    logic [7:0] obs_lane;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input logic e);
        int x_ctr, x_seg, x_lane;
        bit x_load, x_valid, x_done, x_busy;
        x_ctr = 0; x_seg = 0; x_load = 0; x_valid = 0; x_done = 0;
        x_busy = m_active || m_done;
        if (m_done) begin
            x_ctr  = NC - 1;
            x_seg  = NS - 1;
            x_done = e;
        end else if (m_active) begin
            x_seg = m_seg;
            if (m_pos < SEG_LEN) begin
                x_ctr  = m_pos / (SC + 1);
                x_load = ((m_pos % (SC + 1)) == SC) && e;
            end else begin
                x_ctr   = NC - 1;
                x_valid = 1;
            end
        end
        x_lane = (x_ctr < NC - 1) ? FPC : FC - (NC - 1) * FPC;
        check_output("model_ctr", 32'(obs_ctr), x_ctr);
        check_output("model_seg", 32'(obs_seg), x_seg);
        check_output("model_load", 32'(obs_load), 32'(x_load));
        check_output("model_valid", 32'(obs_valid), 32'(x_valid));
        check_output("model_done", 32'(obs_done), 32'(x_done));
        check_output("model_busy", 32'(obs_busy), 32'(x_busy));
        check_output("model_lane", 32'(obs_lane), x_lane);
    endtask

    task automatic model_update(input logic r, e, s, a, rd);
        if (r || a) begin
            m_active = 0; m_done = 0; m_seg = 0; m_pos = 0;
        end else if (e) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_active) begin
                if (m_pos < SEG_LEN) begin
                    m_pos++;
                end else if (rd) begin
                    if (m_seg < NS - 1) begin
                        m_seg++;
                        m_pos = 0;
                    end else begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (s) begin
                m_active = 1; m_seg = 0; m_pos = 0;
            end
        end
    endtask

    // One clock cycle: drive, sample at negedge, check against model, advance model.
    task automatic apply_stimulus(input logic r, e, s, a, rd);
        rst = r; en = e; start = s; abort = a; out_ready = rd;
        @(negedge clk);
        obs_load = load_en; obs_valid = out_valid; obs_done = mapping_done;
        obs_busy = busy; obs_ctr = ctr; obs_seg = hv_segment; obs_lane = lane_count;
        if (m_valid_ref) model_check(e);
        @(posedge clk);
        model_update(r, e, s, a, rd);
        if (r) m_valid_ref = 1;
        #1;
    endtask

    typedef struct {
        logic       start;
        logic       load;
        logic       valid;
        logic       done;
        logic       busy;
        logic [1:0] ctr;
        logic [0:0] seg;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // Nominal pass, out_ready high, start at T0.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'd1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'd1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'd1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'd1};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'd1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'd1};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'd0};

        @(posedge clk);
        #1;
        apply_stimulus(1, 1, 0, 0, 1);
        apply_stimulus(1, 1, 0, 0, 1);

        // Second pass repeats the table with stray start pulses at T5 and T9.
        for (int pass = 0; pass < 2; pass++) begin
            apply_stimulus(1, 1, 0, 0, 1);
            for (int t = 0; t < 21; t++) begin
                apply_stimulus(0, 1, vecs[t].start || (pass == 1 && (t == 5 || t == 9)), 0, 1);
                check_output("tbl_load", 32'(obs_load), 32'(vecs[t].load));
                check_output("tbl_valid", 32'(obs_valid), 32'(vecs[t].valid));
                check_output("tbl_done", 32'(obs_done), 32'(vecs[t].done));
                check_output("tbl_busy", 32'(obs_busy), 32'(vecs[t].busy));
                check_output("tbl_ctr", 32'(obs_ctr), 32'(vecs[t].ctr));
                check_output("tbl_seg", 32'(obs_seg), 32'(vecs[t].seg));
                check_output("tbl_lane", 32'(obs_lane), (vecs[t].ctr == 2'd3) ? 152 : 155);
            end
        end

        // Downstream stall: out_ready low T9..T13.
        apply_stimulus(1, 1, 0, 0, 1);
        for (int t = 0; t < 26; t++) begin
            apply_stimulus(0, 1, t == 0, 0, !(t >= 9 && t <= 13));
            if (t >= 9 && t <= 14) begin
                check_output("stall_valid", 32'(obs_valid), 1);
                check_output("stall_ctr", 32'(obs_ctr), 3);
                check_output("stall_seg", 32'(obs_seg), 0);
            end
            if (t == 15) check_output("stall_load15", 32'(obs_load), 0);
            if (t == 16) check_output("stall_load16", 32'(obs_load), 1);
            if (t == 23) check_output("stall_done23", 32'(obs_done), 0);
            if (t == 24) check_output("stall_done24", 32'(obs_done), 1);
        end

        // Enable dropped for three cycles over the ctr=1 capture.
        apply_stimulus(1, 1, 0, 0, 1);
        for (int t = 0; t < 24; t++) begin
            apply_stimulus(0, !(t >= 4 && t <= 6), t == 0, 0, 1);
            if (t >= 4 && t <= 6) check_output("en_load_off", 32'(obs_load), 0);
            if (t == 7) begin
                check_output("en_load7", 32'(obs_load), 1);
                check_output("en_ctr7", 32'(obs_ctr), 1);
            end
            if (t == 20) check_output("en_load20", 32'(obs_load), 1);
            if (t == 21) check_output("en_done21", 32'(obs_done), 0);
            if (t == 22) check_output("en_done22", 32'(obs_done), 1);
        end

        // Abort mid segment 1, then restart.
        apply_stimulus(1, 1, 0, 0, 1);
        for (int t = 0; t < 18; t++) begin
            apply_stimulus(0, 1, t == 0 || t == 14, t == 12, 1);
            if (t == 13) begin
                check_output("abort_busy", 32'(obs_busy), 0);
                check_output("abort_ctr", 32'(obs_ctr), 0);
                check_output("abort_seg", 32'(obs_seg), 0);
                check_output("abort_done", 32'(obs_done), 0);
            end
            if (t == 16) check_output("abort_restart_load", 32'(obs_load), 1);
        end

        // start together with abort in IDLE.
        apply_stimulus(1, 1, 0, 0, 1);
        apply_stimulus(0, 1, 1, 1, 1);
        apply_stimulus(0, 1, 0, 0, 1);
        check_output("start_abort_busy", 32'(obs_busy), 0);

        // Synchronous reset mid-pass.
        for (int t = 0; t < 12; t++) begin
            apply_stimulus(t == 10, 1, t == 0, 0, 1);
            if (t == 11) begin
                check_output("rst_busy", 32'(obs_busy), 0);
                check_output("rst_load", 32'(obs_load), 0);
                check_output("rst_valid", 32'(obs_valid), 0);
                check_output("rst_ctr", 32'(obs_ctr), 0);
                check_output("rst_seg", 32'(obs_seg), 0);
            end
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0,
                           ($urandom % 40) == 0, ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
